toggle_cover_detect: RTL and testbench

- Per-bit toggle detector that produces the `valid` vector consumed by the toggle-coverage reporting stage, which issues one coverage callback per asserted bit.
- Watches a WIDTH-bit group of design signals and records rising and falling edges per bit.
- Emits a single-cycle pulse on a bit the first time that bit has shown both a 0->1 and a 1->0 transition since reset or clear, so each coverage point is reported exactly once.
- Also keeps a running count of covered bits for coverage-closure status.

---
 rtl/toggle_cover_detect.sv | 96 +++++++++
 tb/tb_toggle_cover_detect.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/toggle_cover_detect.sv
// Per-bit toggle coverage detector: flags each bit the first time it has shown
// both a rising and a falling edge, and keeps a running count of covered bits.
// Latency: the completing edge sampled at posedge k pulses valid during cycle k+1.
// Backpressure: none; the reporter must accept a valid pulse in the cycle it appears.
//
// Ports:
//   clock          sole clock, posedge
//   reset          asynchronous active-low reset
//   sample         monitored signal values, sampled when enable is high
//   enable         sample qualifier; disabled cycles are skipped entirely
//   clear          synchronous coverage clear, overrides enable
//   valid          one-cycle "newly covered" pulse per bit
//   covered_count  number of bits covered since reset/clear
//   all_covered    high once every bit is covered
module toggle_cover_detect #(
  parameter int WIDTH = 65,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  logic [WIDTH-1:0] prev;
  logic             prev_vld;
  logic [WIDTH-1:0] rise_seen;
  logic [WIDTH-1:0] fall_seen;
  logic [WIDTH-1:0] done;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rs_n;
  logic [WIDTH-1:0] fs_n;
  logic [WIDTH-1:0] newly;
  logic [CNT_W-1:0] newly_cnt;

  // Edges are measured against the last enabled sample, not the last cycle.
  always_comb begin
    rise  = sample & ~prev;
    fall  = ~sample & prev;
    rs_n  = rise_seen | rise;
    fs_n  = fall_seen | fall;
    newly = rs_n & fs_n & ~done;
  end

  // Several bits can complete in one cycle; the count adds all of them.
  always_comb begin
    newly_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      newly_cnt = newly_cnt + CNT_W'(newly[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev          <= '0;
      prev_vld      <= 1'b0;
      rise_seen     <= '0;
      fall_seen     <= '0;
      done          <= '0;
      valid         <= '0;
      covered_count <= '0;
    end else if (clear) begin
      // prev is left alone: prev_vld=0 makes the next enabled sample a baseline.
      prev_vld      <= 1'b0;
      rise_seen     <= '0;
      fall_seen     <= '0;
      done          <= '0;
      valid         <= '0;
      covered_count <= '0;
    end else if (enable) begin
      prev <= sample;
      if (!prev_vld) begin
        prev_vld <= 1'b1;
        valid    <= '0;
      end else begin
        rise_seen     <= rs_n;
        fall_seen     <= fs_n;
        done          <= done | newly;
        valid         <= newly;
        covered_count <= covered_count + newly_cnt;
      end
    end else begin
      valid <= '0;
    end
  end

  // done bits are exclusive, so the count saturates naturally at WIDTH.
  assign all_covered = (covered_count == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_detect.sv
module tb_toggle_cover_detect;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] sample;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] valid;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  int checks = 0;
  int errors = 0;

  toggle_cover_detect #(.WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .sample        (sample),
    .enable        (enable),
    .clear         (clear),
    .valid         (valid),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of inputs, let the posedge take them, look 1 time unit later.
  task automatic drive(input logic [WIDTH-1:0] s, input logic en, input logic clr);
    sample = s;
    enable = en;
    clear  = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sample = '0; enable = 1'b0; clear = 1'b0;
    #1;
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", valid); end
    checks++; if (covered_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", covered_count); end
    checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL reset_all: got %b want 0", all_covered); end
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_baseline();
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL base_valid0: got %b want 0000", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL base_valid1: got %b want 0000", valid); end
    checks++; if (covered_count !== 3'd0) begin errors++; $display("FAIL base_count: got %0d want 0", covered_count); end
  endtask

  task automatic test_single_toggle();
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL single_rise_only: got %b want 0000", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0001) begin errors++; $display("FAIL single_pulse: got %b want 0001", valid); end
    checks++; if (covered_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", covered_count); end
    drive(4'b0001, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL single_one_cycle: got %b want 0000", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL single_no_repeat: got %b want 0000", valid); end
    checks++; if (covered_count !== 3'd1) begin errors++; $display("FAIL single_count_hold: got %0d want 1", covered_count); end
  endtask

  task automatic test_multi_saturate();
    drive(4'b0000, 1'b0, 1'b1);
    checks++; if (covered_count !== 3'd0) begin errors++; $display("FAIL multi_clear_count: got %0d want 0", covered_count); end
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 1'b0);
    checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL multi_all_early: got %b want 0", all_covered); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b1111) begin errors++; $display("FAIL multi_pulse: got %b want 1111", valid); end
    checks++; if (covered_count !== 3'd4) begin errors++; $display("FAIL multi_count: got %0d want 4", covered_count); end
    checks++; if (all_covered !== 1'b1) begin errors++; $display("FAIL multi_all: got %b want 1", all_covered); end
    drive(4'b1111, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL multi_after0: got %b want 0000", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL multi_after1: got %b want 0000", valid); end
    checks++; if (covered_count !== 3'd4) begin errors++; $display("FAIL multi_count_sat: got %0d want 4", covered_count); end
    checks++; if (all_covered !== 1'b1) begin errors++; $display("FAIL multi_all_hold: got %b want 1", all_covered); end
  endtask

  task automatic test_enable_gating();
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL gate_disabled: got %b want 0000", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL gate_no_fall: got %b want 0000", valid); end
    drive(4'b0001, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL gate_rise: got %b want 0000", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0001) begin errors++; $display("FAIL gate_pulse: got %b want 0001", valid); end
    checks++; if (covered_count !== 3'd1) begin errors++; $display("FAIL gate_count: got %0d want 1", covered_count); end
    drive(4'b0001, 1'b0, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL gate_valid_drop: got %b want 0000", valid); end
  endtask

  task automatic test_clear_priority();
    drive(4'b0001, 1'b1, 1'b1);
    checks++; if (covered_count !== 3'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", covered_count); end
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL clr_valid: got %b want 0000", valid); end
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL clr_fall_only: got %b want 0000", valid); end
    drive(4'b0001, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0001) begin errors++; $display("FAIL clr_recover: got %b want 0001", valid); end
    checks++; if (covered_count !== 3'd1) begin errors++; $display("FAIL clr_recount: got %0d want 1", covered_count); end
  endtask

  task automatic test_back_to_back();
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0001) begin errors++; $display("FAIL b2b_first: got %b want 0001", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0010) begin errors++; $display("FAIL b2b_second: got %b want 0010", valid); end
    checks++; if (covered_count !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", covered_count); end
  endtask

  task automatic test_async_reset();
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0111, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0111) begin errors++; $display("FAIL ar_pre_valid: got %b want 0111", valid); end
    checks++; if (covered_count !== 3'd3) begin errors++; $display("FAIL ar_pre_count: got %0d want 3", covered_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL ar_valid: got %b want 0000", valid); end
    checks++; if (covered_count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", covered_count); end
    checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL ar_all: got %b want 0", all_covered); end
    #1;
    reset = 1'b1;
    drive(4'b1111, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL ar_baseline: got %b want 0000", valid); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL ar_fall_only: got %b want 0000", valid); end
    drive(4'b1111, 1'b1, 1'b0);
    checks++; if (valid !== 4'b1111) begin errors++; $display("FAIL ar_recover: got %b want 1111", valid); end
    checks++; if (covered_count !== 3'd4) begin errors++; $display("FAIL ar_count_after: got %0d want 4", covered_count); end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_single_toggle();
    test_multi_saturate();
    test_enable_gating();
    test_clear_priority();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
